rv32i_pipe_chain: RTL and testbench

//  Parametrised in-order pipeline register chain for the RV32I core. Carries a

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/rv32i_pipe_stage.sv | 45 ++++
 rtl/rv32i_pipe_chain.sv | 109 ++++++++++
 tb/tb_rv32i_pipe_chain.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: type codes, bubble constants, stage select.
package rv32i_pkg;
  localparam int TYPE_W = 4;
  localparam int XLEN   = 32;

  // Decoded type codes, shared with rv32i_decoder.
  localparam logic [TYPE_W-1:0] TYPE_NONE = 4'd0;
  localparam logic [TYPE_W-1:0] TYPE_R    = 4'd1;
  localparam logic [TYPE_W-1:0] TYPE_I    = 4'd2;
  localparam logic [TYPE_W-1:0] TYPE_S    = 4'd3;
  localparam logic [TYPE_W-1:0] TYPE_B    = 4'd4;
  localparam logic [TYPE_W-1:0] TYPE_U    = 4'd5;
  localparam logic [TYPE_W-1:0] TYPE_J    = 4'd6;
  localparam logic [TYPE_W-1:0] TYPE_LOAD = 4'd7;
  localparam logic [TYPE_W-1:0] TYPE_SYS  = 4'd8;

  // A bubble is an invalid, fully zeroed bundle.
  localparam logic              BUBBLE_VALID = 1'b0;
  localparam logic [XLEN-1:0]   BUBBLE_WORD  = '0;
  localparam logic [TYPE_W-1:0] BUBBLE_TYPE  = '0;

  // What a stage register does at the next edge.
  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_BUBBLE,
    SEL_PREV
  } stage_sel_e;
endpackage

// File: rtl/rv32i_pipe_stage.sv
// One pipeline stage register: hold, load a bubble, or load the previous stage.
module rv32i_pipe_stage
  import rv32i_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int TYPE_W = rv32i_pkg::TYPE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              load_bubble,
  input  logic              load_prev,
  input  logic              prev_valid,
  input  logic [WIDTH-1:0]  prev_inst,
  input  logic [WIDTH-1:0]  prev_imm,
  input  logic [TYPE_W-1:0] prev_type,
  output logic              q_valid,
  output logic [WIDTH-1:0]  q_inst,
  output logic [WIDTH-1:0]  q_imm,
  output logic [TYPE_W-1:0] q_type
);

  // Stage register; hold wins over bubble, bubble wins over load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid <= BUBBLE_VALID;
      q_inst  <= '0;
      q_imm   <= '0;
      q_type  <= '0;
    end else if (!hold) begin
      if (load_bubble) begin
        q_valid <= BUBBLE_VALID;
        q_inst  <= '0;
        q_imm   <= '0;
        q_type  <= '0;
      end else if (load_prev) begin
        q_valid <= prev_valid;
        q_inst  <= prev_inst;
        q_imm   <= prev_imm;
        q_type  <= prev_type;
      end
    end
  end

endmodule

// File: rtl/rv32i_pipe_chain.sv
// In-order pipeline register chain with stall, flush and retire counter.
module rv32i_pipe_chain
  import rv32i_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int TYPE_W       = rv32i_pkg::TYPE_W,
  parameter int DEPTH        = 3,
  parameter int HOLD_STAGE   = 0,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_inst,
  input  logic [WIDTH-1:0]        in_imm,
  input  logic [TYPE_W-1:0]       in_type,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    in_ready,
  output logic [DEPTH-1:0]        stage_valid,
  output logic [DEPTH*WIDTH-1:0]  stage_inst,
  output logic [DEPTH*WIDTH-1:0]  stage_imm,
  output logic [DEPTH*TYPE_W-1:0] stage_type,
  output logic [31:0]             retire_count
);

  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("rv32i_pipe_chain: DEPTH must be in 2..8");
  end
  if (HOLD_STAGE < 0 || HOLD_STAGE >= DEPTH) begin : g_bad_hold
    $error("rv32i_pipe_chain: HOLD_STAGE must be in 0..DEPTH-1");
  end
  if (FLUSH_STAGES < 1 || FLUSH_STAGES > DEPTH) begin : g_bad_flush
    $error("rv32i_pipe_chain: FLUSH_STAGES must be in 1..DEPTH");
  end

  logic [DEPTH-1:0]             sv;
  logic [DEPTH-1:0][WIDTH-1:0]  si;
  logic [DEPTH-1:0][WIDTH-1:0]  sm;
  logic [DEPTH-1:0][TYPE_W-1:0] st;
  stage_sel_e                   sel [DEPTH];
  logic [31:0]                  retire_q;

  assign in_ready = !stall || flush;

  // Per-stage select: flush dominates stall; a stall parks a bubble just past the held group.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      sel[k] = SEL_PREV;
      if (flush) begin
        sel[k] = (k < FLUSH_STAGES) ? SEL_BUBBLE : SEL_PREV;
      end else if (stall) begin
        if (k <= HOLD_STAGE)          sel[k] = SEL_HOLD;
        else if (k == HOLD_STAGE + 1) sel[k] = SEL_BUBBLE;
        else                          sel[k] = SEL_PREV;
      end else if (k == 0) begin
        sel[k] = in_valid ? SEL_PREV : SEL_BUBBLE;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              p_valid;
    logic [WIDTH-1:0]  p_inst;
    logic [WIDTH-1:0]  p_imm;
    logic [TYPE_W-1:0] p_type;

    if (k == 0) begin : g_head
      assign p_valid = in_valid;
      assign p_inst  = in_inst;
      assign p_imm   = in_imm;
      assign p_type  = in_type;
    end else begin : g_body
      assign p_valid = sv[k-1];
      assign p_inst  = si[k-1];
      assign p_imm   = sm[k-1];
      assign p_type  = st[k-1];
    end

    rv32i_pipe_stage #(.WIDTH(WIDTH), .TYPE_W(TYPE_W)) u_stage (
      .clk         (clk),
      .reset       (reset),
      .hold        (sel[k] == SEL_HOLD),
      .load_bubble (sel[k] == SEL_BUBBLE),
      .load_prev   (sel[k] == SEL_PREV),
      .prev_valid  (p_valid),
      .prev_inst   (p_inst),
      .prev_imm    (p_imm),
      .prev_type   (p_type),
      .q_valid     (sv[k]),
      .q_inst      (si[k]),
      .q_imm       (sm[k]),
      .q_type      (st[k])
    );
  end

  // Count a retire whenever a valid oldest bundle is replaced (a flush does not cancel it).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_q <= '0;
    else if (sv[DEPTH-1] && sel[DEPTH-1] != SEL_HOLD) retire_q <= retire_q + 32'd1;
  end

  assign stage_valid  = sv;
  assign stage_inst   = si;
  assign stage_imm    = sm;
  assign stage_type   = st;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_rv32i_pipe_chain.sv
// Directed bench for rv32i_pipe_chain with a stage-2 arrival scoreboard.
module tb_rv32i_pipe_chain;
  logic        clk, rst;
  logic        in_valid, stall, flush, h_stall;
  logic [31:0] in_inst, in_imm;
  logic [3:0]  in_type;
  logic        in_ready, h_in_ready;
  logic [2:0]  stage_valid, h_valid;
  logic [95:0] stage_inst, stage_imm, h_inst, h_imm;
  logic [11:0] stage_type, h_type;
  logic [31:0] retire_count, h_retire;
  logic        h_flush;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  rv32i_pipe_chain dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_inst(in_inst), .in_imm(in_imm),
    .in_type(in_type), .stall(stall), .flush(flush), .in_ready(in_ready),
    .stage_valid(stage_valid), .stage_inst(stage_inst), .stage_imm(stage_imm),
    .stage_type(stage_type), .retire_count(retire_count)
  );

  rv32i_pipe_chain #(.HOLD_STAGE(2)) dut_h (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_inst(in_inst), .in_imm(in_imm),
    .in_type(in_type), .stall(h_stall), .flush(h_flush), .in_ready(h_in_ready),
    .stage_valid(h_valid), .stage_inst(h_inst), .stage_imm(h_imm),
    .stage_type(h_type), .retire_count(h_retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] s_inst(input int k);
    return stage_inst[k*32 +: 32];
  endfunction

  // Drive one cycle of stimulus, advance one edge, then score any stage-2 arrival.
  task automatic step(input logic v, input logic [31:0] inst, input logic st, input logic fl);
    logic [31:0] e;
    in_valid = v; in_inst = inst; in_imm = inst + 32'd1; in_type = inst[3:0] ^ 4'h5;
    stall = st; flush = fl;
    #1 chk("in_ready", {127'd0, in_ready}, {127'd0, (!st || fl)});
    if (v && !st && !fl) sb.push_back(inst);
    @(posedge clk); #1;
    if (stage_valid[2]) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {96'd0, s_inst(2)}, 128'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_inst", {96'd0, s_inst(2)}, {96'd0, e});
        chk("sb_imm",  {96'd0, stage_imm[64 +: 32]}, {96'd0, e + 32'd1});
        chk("sb_type", {124'd0, stage_type[8 +: 4]}, {124'd0, e[3:0] ^ 4'h5});
      end
    end
  endtask

  task automatic chk_bubble(input string tag, input int k);
    chk({tag, "_v"},    {127'd0, stage_valid[k]}, 128'd0);
    chk({tag, "_inst"}, {96'd0, s_inst(k)}, 128'd0);
    chk({tag, "_imm"},  {96'd0, stage_imm[k*32 +: 32]}, 128'd0);
    chk({tag, "_type"}, {124'd0, stage_type[k*4 +: 4]}, 128'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_inst = 0; in_imm = 0; in_type = 0;
    stall = 0; flush = 0; h_stall = 0; h_flush = 0;
    #12;
    chk("rst_valid", {125'd0, stage_valid}, 128'd0);
    chk("rst_inst",  {32'd0, stage_inst}, 128'd0);
    chk("rst_retire", {96'd0, retire_count}, 128'd0);
    rst = 1'b0;

    // Stream three instructions
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00200113, 0, 0);
    step(1, 32'h00300193, 0, 0);
    chk("t1_s2", {96'd0, s_inst(2)}, {96'd0, 32'h00100093});
    chk("t1_s1", {96'd0, s_inst(1)}, {96'd0, 32'h00200113});
    chk("t1_s0", {96'd0, s_inst(0)}, {96'd0, 32'h00300193});
    chk("t1_valid", {125'd0, stage_valid}, {125'd0, 3'b111});
    chk("t1_ret0", {96'd0, retire_count}, 128'd0);
    step(0, 32'h0, 0, 0);
    chk("t1_ret1", {96'd0, retire_count}, {96'd0, 32'd1});
    chk_bubble("t1_s0b", 0);

    // Stall two cycles holding stage 0
    step(1, 32'h00500293, 0, 0);
    chk("t2_ret2", {96'd0, retire_count}, {96'd0, 32'd2});
    for (int c = 0; c < 2; c++) begin
      step(1, 32'hdeadbeef, 1, 0);
      chk("t2_hold", {96'd0, s_inst(0)}, {96'd0, 32'h00500293});
      chk("t2_hold_v", {127'd0, stage_valid[0]}, {127'd0, 1'b1});
      chk_bubble("t2_s1", 1);
      chk_bubble("t2_s2", 2);
      chk("t2_ret", {96'd0, retire_count}, {96'd0, 32'd3});
    end
    step(0, 32'h0, 0, 0);
    chk("t2_resume", {96'd0, s_inst(1)}, {96'd0, 32'h00500293});
    step(0, 32'h0, 0, 0);
    step(0, 32'h0, 0, 0);
    chk("t2_ret4", {96'd0, retire_count}, {96'd0, 32'd4});

    // Flush with {0x11,0x22,0x33} in stages 0..2
    step(1, 32'h33, 0, 0);
    step(1, 32'h22, 0, 0);
    step(1, 32'h11, 0, 0);
    void'(sb.pop_back());
    step(1, 32'h44, 0, 1);
    chk_bubble("t3_s0", 0);
    chk_bubble("t3_s1", 1);
    chk("t3_s2", {96'd0, s_inst(2)}, {96'd0, 32'h22});
    chk("t3_ret", {96'd0, retire_count}, {96'd0, 32'd5});

    // Stall and flush together
    step(0, 32'h0, 0, 0);
    chk("t4_ret6", {96'd0, retire_count}, {96'd0, 32'd6});
    step(1, 32'h33, 0, 0);
    step(1, 32'h22, 0, 0);
    step(1, 32'h11, 0, 0);
    void'(sb.pop_back());
    step(1, 32'h44, 1, 1);
    chk_bubble("t4_s0", 0);
    chk_bubble("t4_s1", 1);
    chk("t4_s2", {96'd0, s_inst(2)}, {96'd0, 32'h22});
    chk("t4_ret", {96'd0, retire_count}, {96'd0, 32'd7});

    // Counter wrap
    @(negedge clk);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1 release dut.retire_q;
    chk("t6_pre", {96'd0, retire_count}, {96'd0, 32'hFFFF_FFFF});
    step(0, 32'h0, 0, 0);
    chk("t6_wrap", {96'd0, retire_count}, 128'd0);

    // Reset pulse mid-stream, checked before any edge
    step(1, 32'h55, 0, 0);
    step(1, 32'h66, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", {125'd0, stage_valid}, 128'd0);
    chk("rst_mid_inst",  {32'd0, stage_inst}, 128'd0);
    chk("rst_mid_imm",   {32'd0, stage_imm}, 128'd0);
    chk("rst_mid_type",  {116'd0, stage_type}, 128'd0);
    chk("rst_mid_h",     {125'd0, h_valid}, 128'd0);
    sb.delete();
    rst = 1'b0;

    // First edge after reset is normal; fill HOLD_STAGE=2 instance
    step(1, 32'h77, 0, 0);
    chk("post_rst_s0", {96'd0, s_inst(0)}, {96'd0, 32'h77});
    chk("post_rst_v",  {125'd0, stage_valid}, {125'd0, 3'b001});
    step(1, 32'h88, 0, 0);
    step(1, 32'h99, 0, 0);
    chk("t5_fill", {32'd0, h_inst}, {32'd0, 32'h77, 32'h88, 32'h99});
    h_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(0, 32'h0, 0, 0);
      chk("t5_ready", {127'd0, h_in_ready}, 128'd0);
      chk("t5_frozen", {32'd0, h_inst}, {32'd0, 32'h77, 32'h88, 32'h99});
      chk("t5_valid", {125'd0, h_valid}, {125'd0, 3'b111});
      chk("t5_ret", {96'd0, h_retire}, 128'd0);
    end
    h_stall = 1'b0;
    step(0, 32'h0, 0, 0);
    chk("t5_release", {96'd0, h_retire}, {96'd0, 32'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
